// File: rtl/toggle_sender_sched.sv
// toggle_sender_sched: round-robin scheduler that shares one data/en
// pulse channel between N_REQ requesters ahead of a toggle sender.
// After each pulse it holds a programmable quiet gap so the slow
// domain never misses a toggle.
//
// Ports:
//   clk       fast-domain clock
//   rst       synchronous reset, active-high
//   req       per-requester request, held until granted
//   req_data  payloads, requester i at [i*DATA_W +: DATA_W]
//   gap_min   quiet cycles after each pulse (sampled in SEND)
//   grant     one-hot winner, high only while en=1
//   data      payload of the last grant, held between pulses
//   en        single-cycle send strobe
//   busy      high whenever the scheduler is not idle
//   sent_cnt  pulses issued, wraps silently
module toggle_sender_sched #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 4,
    parameter int GAP_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [GAP_W-1:0]        gap_min,
    output logic [N_REQ-1:0]        grant,
    output logic [DATA_W-1:0]       data,
    output logic                    en,
    output logic                    busy,
    output logic [15:0]             sent_cnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_n;
    logic [GAP_W-1:0]   cnt;
    logic [GAP_W-1:0]   cnt_n;
    logic               en_n;
    logic [N_REQ-1:0]   grant_n;
    logic [DATA_W-1:0]  data_n;
    logic [15:0]        sent_n;

    logic               found;
    logic [PTR_W-1:0]   win;
    logic [N_REQ-1:0]   win_oh;
    logic [DATA_W-1:0]  win_data;
    logic [PTR_W-1:0]   win_next;

    // Circular scan starting at ptr; the first set request wins.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        logic             hit;
        found = 1'b0;
        win   = '0;
        sum   = '0;
        idx   = '0;
        hit   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N_REQ)) begin
                sum = sum - (PTR_W+1)'(N_REQ);
            end
            idx = sum[PTR_W-1:0];
            hit = 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                if (idx == PTR_W'(i)) begin
                    hit = req[i];
                end
            end
            if (!found && hit) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_oh   = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == PTR_W'(i)) begin
                win_oh[i] = 1'b1;
                win_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
        if (win == PTR_W'(N_REQ - 1)) begin
            win_next = '0;
        end else begin
            win_next = win + PTR_W'(1);
        end
    end

    always_comb begin
        state_n = state;
        en_n    = 1'b0;
        grant_n = '0;
        data_n  = data;
        ptr_n   = ptr;
        cnt_n   = cnt;
        sent_n  = sent_cnt;
        unique case (state)
            IDLE: begin
                if (found) begin
                    en_n    = 1'b1;
                    grant_n = win_oh;
                    data_n  = win_data;
                    ptr_n   = win_next;
                    sent_n  = sent_cnt + 16'd1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (gap_min != '0) begin
                    cnt_n   = gap_min;
                    state_n = GAP;
                end else begin
                    state_n = IDLE;
                end
            end
            GAP: begin
                if (cnt == GAP_W'(1)) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - GAP_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            en       <= 1'b0;
            grant    <= '0;
            data     <= '0;
            ptr      <= '0;
            cnt      <= '0;
            sent_cnt <= '0;
        end else begin
            state    <= state_n;
            en       <= en_n;
            grant    <= grant_n;
            data     <= data_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            sent_cnt <= sent_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_toggle_sender_sched.sv
// tb_toggle_sender_sched: directed bench for toggle_sender_sched with a
// timing-based reference model checked every cycle.
module tb_toggle_sender_sched;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int GW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic [GW-1:0] gap_min;
    logic [N-1:0]  grant;
    logic [DW-1:0] data;
    logic          en;
    logic          busy;
    logic [15:0]   sent_cnt;

    toggle_sender_sched #(
        .N_REQ (N),
        .DATA_W(DW),
        .GAP_W (GW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_data(req_data),
        .gap_min (gap_min),
        .grant   (grant),
        .data    (data),
        .en      (en),
        .busy    (busy),
        .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: n counts sampling edges. Arbitration may happen
    // at edge n only when n >= next_ok; a pulse at edge c blocks until
    // c+2+gap, where gap is read one edge after the pulse.
    int            n = 0;
    int            next_ok = 0;
    bit            pend = 0;
    int            m_ptr = 0;
    logic          m_en = 0;
    logic [N-1:0]  m_grant = '0;
    logic [DW-1:0] m_data = '0;
    logic [15:0]   m_cnt = '0;
    logic          m_busy = 0;

    initial begin
        forever begin
            @(posedge clk);
            n++;
            if (rst) begin
                m_en = 0; m_grant = '0; m_data = '0; m_cnt = '0;
                m_ptr = 0; next_ok = n + 1; pend = 0;
            end else begin
                m_en = 0;
                m_grant = '0;
                if (pend) begin
                    next_ok = n + 1 + int'(gap_min);
                    pend = 0;
                end else if (n >= next_ok && req != '0) begin
                    for (int k = 0; k < N; k++) begin
                        int idx;
                        idx = (m_ptr + k) % N;
                        if (!m_en && req[idx]) begin
                            m_en = 1;
                            m_grant = '0;
                            m_grant[idx] = 1'b1;
                            m_data = req_data[idx*DW +: DW];
                            m_ptr = (idx + 1) % N;
                        end
                    end
                    m_cnt = m_cnt + 16'd1;
                    next_ok = n + 2;
                    pend = 1;
                end
            end
            m_busy = (n + 1 < next_ok);
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("cyc_en", en, m_en);
            chk("cyc_grant", grant, m_grant);
            chk("cyc_data", data, m_data);
            chk("cyc_sent_cnt", sent_cnt, m_cnt);
            chk("cyc_busy", busy, m_busy);
        end
    end

    task automatic wait_en(input string name, input int budget,
                           output int t);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (en !== 1'b1 && k < budget);
        checks++;
        if (en !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: got en=%b expected 1", name, en);
        end
        t = n;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, t3, ts, bc;
        rst = 1'b1;
        req = 4'hF;
        gap_min = '0;
        req_data = {4'h3, 4'hA, 4'h5, 4'h1};

        // 1. reset held with all requests up
        repeat (3) begin
            @(negedge clk);
            chk("rst_en", en, 0);
            chk("rst_grant", grant, 0);
            chk("rst_data", data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_cnt", sent_cnt, 0);
        end
        rst = 1'b0;
        wait_en("t1", 10, t1);
        chk("t1_grant", grant, 4'b0001);
        chk("t1_data", data, 4'h1);
        req = '0;
        wait_idle(20);

        // 2. single requester, gap 3
        do_reset();
        gap_min = 8'd3;
        req = 4'b0100;
        wait_en("t2a", 10, t1);
        chk("t2_grant", grant, 4'b0100);
        chk("t2_data", data, 4'hA);
        chk("t2_cnt", sent_cnt, 1);
        bc = 0;
        while (busy === 1'b1 && bc < 20) begin
            bc++;
            @(negedge clk);
        end
        chk("t2_busy_len", bc, 4);
        wait_en("t2b", 10, t2);
        chk("t2_spacing", t2 - t1, 5);
        req = '0;
        wait_idle(20);

        // 3. full contention, gap 0
        do_reset();
        gap_min = 8'd0;
        req = 4'hF;
        t1 = 0;
        for (int i = 0; i < 6; i++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (i % 4);
            wait_en("t3", 10, t2);
            chk("t3_grant", grant, exp_g);
            if (i > 0) chk("t3_spacing", t2 - t1, 2);
            t1 = t2;
        end
        chk("t3_cnt", sent_cnt, 6);
        @(negedge clk);
        req = '0;
        wait_idle(20);

        // 4. pointer now at 2: requester 3 beats 0, then 0
        req = 4'b1001;
        wait_en("t4a", 10, t1);
        chk("t4_grant_a", grant, 4'b1000);
        chk("t4_data_a", data, 4'h3);
        wait_en("t4b", 10, t1);
        chk("t4_grant_b", grant, 4'b0001);
        req = '0;
        wait_idle(20);

        // 5. long gap, then changed mid-gap
        gap_min = 8'd255;
        req = 4'b0010;
        wait_en("t5a", 10, t1);
        repeat (10) @(negedge clk);
        gap_min = 8'd2;
        wait_en("t5b", 300, t2);
        chk("t5_spacing_255", t2 - t1, 257);
        wait_en("t5c", 20, t3);
        chk("t5_spacing_2", t3 - t2, 4);
        req = '0;
        wait_idle(20);

        // 6. reset in the middle of a gap
        gap_min = 8'd10;
        req = 4'b0001;
        wait_en("t6a", 10, t1);
        repeat (4) @(negedge clk);
        chk("t6_busy_pre", busy, 1);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_en", en, 0);
        chk("t6_grant", grant, 0);
        rst = 1'b0;
        req = 4'b0011;
        ts = n;
        wait_en("t6b", 10, t2);
        chk("t6_latency", t2 - ts, 1);
        chk("t6_grant_ptr0", grant, 4'b0001);
        req = '0;
        wait_idle(30);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_sender_sched.md
Name: toggle_sender_sched

Overview:
- Round-robin scheduler that shares one data/en pulse channel between N_REQ requesters.
- The channel feeds the toggle-based enable synchronizer of the CDC lab.
- Issues one single-cycle en pulse per grant and enforces a programmable minimum quiet gap between pulses so the slow domain never misses a toggle.
- Sits between stimulus/producer blocks and the toggle sender in the fast domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 4, payload width
GAP_W, 8, width of gap_min and gap counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req  in  N_REQ  per-requester request; held high with stable payload until granted
req_data  in  N_REQ*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W]
gap_min  in  GAP_W  quiet cycles inserted after each pulse
grant  out  N_REQ  one-hot, high only in the cycle en=1
data  out  DATA_W  payload of last grant; held between pulses
en  out  1  single-cycle send strobe
busy  out  1  high whenever state != IDLE
sent_cnt  out  16  number of pulses issued, wraps 65535->0

Behaviour:
- States: IDLE, SEND, GAP. All outputs except busy are registered; busy decodes the state register.
- Reset, synchronous, dominates everything:
  - state=IDLE, en=0, grant=0, data=0, sent_cnt=0.
  - RR pointer=0 (requester 0 has top priority).
  - gap counter=0.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise the winner is the first set req bit scanning circularly from the pointer.
  - Next edge: en<=1, grant<=onehot(winner), data<=winner payload, pointer<=(winner+1) mod N_REQ, sent_cnt<=sent_cnt+1, state<=SEND.
- SEND: lasts exactly 1 cycle.
  - Next edge: en<=0, grant<=0, data holds.
  - gap_min sampled here: if gap_min!=0 then cnt<=gap_min, state<=GAP; else state<=IDLE.
- GAP: lasts exactly the sampled gap_min cycles.
  - cnt==1 -> IDLE; otherwise cnt<=cnt-1.
  - req is ignored in GAP.
  - Changes to gap_min during GAP take effect at the next SEND.
- Timing:
  - req sampled high in IDLE at cycle t -> en high at t+1.
  - Minimum en-to-en spacing is gap_min+2 cycles; with gap_min=0 pulses come every 2nd cycle.
  - The mandatory IDLE cycle lets a requester drop req on the edge after its grant without being re-granted.
- Requester rules:
  - A requester may withdraw req before grant; only the value sampled in IDLE counts.
  - A requester that keeps req high after grant re-competes at its new (lowest) RR position.
- Reset mid-SEND or mid-GAP: en, grant and busy are low the cycle after reset is sampled; any in-flight gap is abandoned.
- sent_cnt wraps 16'hFFFF -> 0 with no flag.

Test Plan:
1. Reset check: hold rst 3 cycles with req=4'hF -> en=0, grant=0, data=0, busy=0, sent_cnt=0 throughout; after release the first grant goes to requester 0.
2. Single requester: req=4'b0100, payload2=4'hA, gap_min=3 -> en at t+1 with grant=4'b0100, data=4'hA, sent_cnt=1; busy for 4 cycles (1 SEND + 3 GAP); with req still high, next en lands exactly 5 cycles after the first.
3. Full contention: req=4'hF held continuously, gap_min=0 -> grants 0,1,2,3,0,1 on en every 2nd cycle; sent_cnt=6 after 6 pulses.
4. Pointer rotation: after grant to requester 1, assert req=4'b1001 -> requester 3 wins; next grant goes to requester 0.
5. Long/changing gap: gap_min=255 -> 257-cycle en spacing; change gap_min to 2 mid-GAP -> current gap stays 255, following gap is 2.
6. Reset mid-GAP: gap_min=10, assert rst at GAP cycle 4 -> busy=0 and pointer=0 next cycle; first post-reset en occurs 1 cycle after req is seen in IDLE.
